// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   state_e    : fetch FSM states (idle after reset, request, hold output)
//   INSTR_W    : instruction word width
//   OPCODE_MSB : top bit of the opcode field inside an instruction
//   OPCODE_LSB : bottom bit of the opcode field inside an instruction
//   PC_STEP    : byte increment between sequential instructions
// ----------------------------------------------------------------------------
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned PC_STEP    = 4;

endpackage : ifetch_pkg

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Instruction-fetch stage feeding the main control decoder. Owns the PC,
// issues one word request at a time to instruction memory over a req/ack
// handshake, and holds the fetched word in a one-entry output register until
// downstream accepts it. A redirect pulse from execute retargets the PC and
// squashes any wrong-path fetch or held instruction.
//
// Optional build macro: IFETCH_PERF_CNT_EN adds the fetch_cnt / squash_cnt
// performance counter outputs.
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   imem_req     out  fetch request valid
//   imem_addr    out  word-aligned fetch address
//   imem_ack     in   one-cycle response strobe (may coincide with imem_req)
//   imem_rdata   in   instruction word, valid with imem_ack
//   redirect     in   single-cycle control-transfer pulse
//   redirect_pc  in   transfer target, low two bits ignored
//   instr        out  held instruction, instr[31:26] is the opcode
//   instr_pc     out  address of instr
//   instr_valid  out  instr / instr_pc hold a valid instruction
//   instr_ready  in   downstream accept
//   fetch_cnt    out  accepted transfers (IFETCH_PERF_CNT_EN only)
//   squash_cnt   out  dropped responses + squashed holds (IFETCH_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = ADDR_W'(32'h0000_0000)
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         squash_cnt,
`endif
    input  logic                instr_ready
);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [ADDR_W-1:0]      req_addr_q, req_addr_d;
    logic                   drop_q, drop_d;
    logic                   req_q, req_d;
    logic [INSTR_W-1:0]     instr_q, instr_d;
    logic [ADDR_W-1:0]      instr_pc_q, instr_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0]      redir_tgt_s;

    // Redirect targets are forced onto a word boundary.
    assign redir_tgt_s = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Next-state, next-PC mux and output-register updates; redirect wins over
    // every other event in every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        drop_d        = drop_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            S_IDLE: begin
                // A late ack from before reset lands here and is ignored.
                state_d = S_REQ;
                if (redirect) begin
                    pc_d       = redir_tgt_s;
                    req_addr_d = redir_tgt_s;
                end else begin
                    req_addr_d = pc_q;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    pc_d = redir_tgt_s;
                    if (imem_ack) begin
                        // Request is complete, so retarget immediately.
                        req_addr_d = redir_tgt_s;
                        drop_d     = 1'b0;
                    end else begin
                        // Address must stay stable until the ack; discard that
                        // response when it arrives.
                        drop_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (drop_q) begin
                        drop_d     = 1'b0;
                        req_addr_d = pc_q;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = req_addr_q;
                        instr_valid_d = 1'b1;
                        pc_d          = req_addr_q + ADDR_W'(PC_STEP);
                        state_d       = S_HOLD;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redir_tgt_s;
                    req_addr_d    = redir_tgt_s;
                    state_d       = S_REQ;
                end else if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    req_addr_d    = pc_q;
                    state_d       = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d       = S_IDLE;
                instr_valid_d = 1'b0;
                drop_d        = 1'b0;
            end
        endcase

        req_d = (state_d == S_REQ);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            drop_q        <= 1'b0;
            req_q         <= 1'b0;
            instr_q       <= {INSTR_W{1'b0}};
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            drop_q        <= drop_d;
            req_q         <= req_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = req_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] squash_cnt_q;
    logic        fetch_inc_s;
    logic        squash_inc_s;

    // Event decode: a discarded response is any ack seen while dropping or
    // alongside a redirect; a squash is a redirect hitting the held entry.
    always_comb begin
        fetch_inc_s  = (state_q == S_HOLD) && instr_ready && !redirect;
        squash_inc_s = ((state_q == S_REQ) && imem_ack && (drop_q || redirect)) ||
                       ((state_q == S_HOLD) && redirect);
    end

    // Wrapping performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q  <= 32'd0;
            squash_cnt_q <= 32'd0;
        end else begin
            if (fetch_inc_s) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (squash_inc_s) begin
                squash_cnt_q <= squash_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign squash_cnt = squash_cnt_q;
`endif

endmodule : ifetch_unit

// File: tb/tb_ifetch_unit.sv
// ----------------------------------------------------------------------------
// tb_ifetch_unit
// Scoreboard bench for ifetch_unit. Stimulus pushes the expected request
// addresses and expected downstream transfers into queues; a monitor pops and
// compares whenever the DUT completes a memory handshake or a downstream
// transfer. A small memory responder returns {opcode 6'b100011, address}.
// Inputs change 1-2 time units after the rising edge; everything is sampled
// on the falling edge.
// ----------------------------------------------------------------------------
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] squash_cnt;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] req_exp[$];
    logic [63:0] out_exp[$];
    int          lat       = 0;
    bit          force_ack = 1'b0;
    logic [6:0]  vpat;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
`ifdef IFETCH_PERF_CNT_EN
        .fetch_cnt   (fetch_cnt),
        .squash_cnt  (squash_cnt),
`endif
        .instr_ready (instr_ready)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid_wait"}, 64'(instr_valid), 64'd1);
    endtask

    // Memory responder: acks after `lat` wait cycles; force_ack injects a stray ack.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (force_ack) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                wcnt       = 0;
            end else if (imem_req) begin
                if (wcnt >= lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = 32'h8C00_0000 | imem_addr;
                    wcnt       = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = 32'h0;
                    wcnt++;
                end
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0;
                wcnt       = 0;
            end
        end
    end

    // Monitor: checks every completed request and every accepted transfer.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && imem_req && imem_ack) begin
                if (req_exp.size() == 0) begin
                    chk("unexpected_req", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("req_addr", 64'(imem_addr), 64'(req_exp.pop_front()));
                end
            end
            if (reset_n && instr_valid && instr_ready && !redirect) begin
                if (out_exp.size() == 0) begin
                    chk("unexpected_xfer", {instr, instr_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = out_exp.pop_front();
                    chk("xfer_instr_pc", {instr, instr_pc}, e);
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        vpat        = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_addr", {31'd0, imem_req, imem_addr}, 64'h0);
        chk("rst_instr", {instr, instr_pc}, 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
        chk("rst_cnts", {fetch_cnt, squash_cnt}, 64'h0);
`endif

        // Zero-wait streaming 0x0, 0x4, 0x8, then 0xC is held under stall.
        req_exp.push_back(32'h0);
        req_exp.push_back(32'h4);
        req_exp.push_back(32'h8);
        req_exp.push_back(32'hC);
        out_exp.push_back({32'h8C00_0000, 32'h0});
        out_exp.push_back({32'h8C00_0004, 32'h4});
        out_exp.push_back({32'h8C00_0008, 32'h8});
        tick();
        reset_n = 1'b1;
        repeat (7) begin
            @(negedge clk);
            vpat = {vpat[5:0], instr_valid};
        end
        chk("valid_pattern", 64'(vpat), 64'(7'b0010101));

        // Downstream stall for 5 cycles.
        tick();
        instr_ready = 1'b0;
        wait_valid("stall");
        for (int i = 0; i < 5; i++) begin
            chk("stall_instr", {instr, instr_pc}, {32'h8C00_000C, 32'hC});
            chk("stall_ctl", {62'd0, instr_valid, imem_req}, 64'd2);
            @(negedge clk);
        end

        // Slow memory, redirect to 0x40 while 0x10 is outstanding.
        lat = 3;
        req_exp.push_back(32'h10);
        req_exp.push_back(32'h40);
        out_exp.push_back({32'h8C00_000C, 32'hC});
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("redir_addr_hold", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h10});
        wait_valid("redir40");
        chk("redir40_held", {instr, instr_pc}, {32'h8C00_0040, 32'h40});

        // Redirect to 0x100 while holding 0x40 with instr_ready high.
        lat = 0;
        req_exp.push_back(32'h100);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        instr_ready = 1'b1;
        tick();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        chk("hold_squash", {31'd0, instr_valid, imem_addr}, {31'd0, 1'b0, 32'h100});
        wait_valid("redir100");
        chk("redir100_held", {instr, instr_pc}, {32'h8C00_0100, 32'h100});
`ifdef IFETCH_PERF_CNT_EN
        chk("cnts_mid", {fetch_cnt, squash_cnt}, {32'd4, 32'd2});
`endif

        // Redirect to 0x23 in the same cycle as the ack for 0x104.
        out_exp.push_back({32'h8C00_0100, 32'h100});
        req_exp.push_back(32'h104);
        req_exp.push_back(32'h20);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h23;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("ack_redir_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h20});
        wait_valid("redir20");
        chk("redir20_held", {instr, instr_pc}, {32'h8C00_0020, 32'h20});

        // Reset during an outstanding request, stray ack while idle.
        out_exp.push_back({32'h8C00_0020, 32'h20});
        req_exp.push_back(32'h0);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        reset_n     = 1'b0;
        force_ack   = 1'b1;
        @(negedge clk);
        chk("midrst_state", {30'd0, instr_valid, imem_req, imem_addr}, 64'h0);
`ifdef IFETCH_PERF_CNT_EN
        chk("midrst_cnts", {fetch_cnt, squash_cnt}, 64'h0);
`endif
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_stray_ack", {30'd0, instr_valid, imem_req, imem_addr}, 64'h0);
        tick();
        force_ack = 1'b0;
        wait_valid("restart");
        chk("restart_held", {instr, instr_pc}, {32'h8C00_0000, 32'h0});

        chk("req_queue_drained", 64'(req_exp.size()), 64'd0);
        chk("out_queue_drained", 64'(out_exp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ifetch_unit
